// File: rtl/dm_lane_seq.sv
// dm_lane_seq: BL8 write sequencer for one DDR3 DM lane (clk_div domain).
// Ports: wr_* request in, din/tin/dci_disable out, dly_* ODELAY update path.
module dm_lane_seq #(
  parameter int         WR_PRE_CYCLES  = 1,
  parameter int         WR_POST_CYCLES = 1,
  parameter logic [7:0] ODELAY_VALUE   = 8'd0
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_mask,
  output logic       wr_ready,
  input  logic       term_en,
  input  logic       dly_req,
  input  logic [7:0] dly_value,
  output logic       dly_busy,
  output logic [3:0] din,
  output logic [3:0] tin,
  output logic       dci_disable,
  output logic [7:0] dly_data,
  output logic       set_odelay,
  output logic       ld_odelay,
  output logic       term_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_D0, S_D1, S_POST
  } state_t;

  localparam logic [1:0] PRE_LD =
    2'(WR_PRE_CYCLES > 0 ? WR_PRE_CYCLES - 1 : 0);
  localparam logic [1:0] POST_LD =
    2'(WR_POST_CYCLES > 0 ? WR_POST_CYCLES - 1 : 0);

  state_t     r_state, w_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_mask, w_mask_nxt;
  logic [3:0] r_din, r_tin;
  logic       r_dci, r_term_err;
  logic [7:0] r_dly_data;
  logic       r_set, r_ld, r_busy;
  logic       w_acc, w_dly_acc;
  logic       w_busy_nxt, w_ld_nxt;
  logic       w_nxt_idle;

  // ld_pend and dly_busy share one register: they rise and fall together.
  assign wr_ready = ~rst & ((r_state == S_D1) |
                            (r_state == S_POST) |
                            ((r_state == S_IDLE) & ~r_busy));

  assign w_acc     = wr_valid & wr_ready;
  assign w_dly_acc = dly_req & ~r_busy;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (WR_PRE_CYCLES > 0) begin
            w_nxt     = S_PRE;
            w_cnt_nxt = PRE_LD;
          end else begin
            w_nxt = S_D0;
          end
        end
      end
      S_PRE: begin
        if (r_cnt == 2'd0) w_nxt = S_D0;
        else w_cnt_nxt = r_cnt - 2'd1;
      end
      S_D0: w_nxt = S_D1;
      S_D1: begin
        if (w_acc) begin
          w_nxt = S_D0;
        end else if (WR_POST_CYCLES > 0) begin
          w_nxt     = S_POST;
          w_cnt_nxt = POST_LD;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_POST: begin
        if (w_acc) w_nxt = S_D0;
        else if (r_cnt == 2'd0) w_nxt = S_IDLE;
        else w_cnt_nxt = r_cnt - 2'd1;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_mask_nxt = w_acc ? wr_mask : r_mask;
  assign w_nxt_idle = (w_nxt == S_IDLE);

  // Pending load survives until the ld cycle itself has been issued.
  assign w_busy_nxt = w_dly_acc | (r_busy & ~r_ld);

  // Outputs are registered from next-state values so they line up with
  // the FSM state of the cycle they are presented in.
  assign w_ld_nxt = w_busy_nxt & w_nxt_idle & ~w_dly_acc;

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_mask     <= 8'd0;
      r_din      <= 4'h0;
      r_tin      <= 4'hF;
      r_dci      <= 1'b1;
      r_term_err <= 1'b0;
      r_dly_data <= ODELAY_VALUE;
      r_set      <= 1'b0;
      r_ld       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      if (w_nxt == S_D0)      r_din <= w_mask_nxt[3:0];
      else if (w_nxt == S_D1) r_din <= w_mask_nxt[7:4];
      else                    r_din <= 4'h0;
      r_tin      <= w_nxt_idle ? 4'hF : 4'h0;
      r_dci      <= ~(term_en & w_nxt_idle);
      r_term_err <= r_term_err |
                    (term_en & (r_state != S_IDLE));
      if (w_dly_acc) r_dly_data <= dly_value;
      r_set  <= w_dly_acc;
      r_ld   <= w_ld_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign din         = r_din;
  assign tin         = r_tin;
  assign dci_disable = r_dci;
  assign term_err    = r_term_err;
  assign dly_data    = r_dly_data;
  assign set_odelay  = r_set;
  assign ld_odelay   = r_ld;
  assign dly_busy    = r_busy;

endmodule

// File: doc/dm_lane_seq.md
# dm_lane_seq

Write-side sequencer for a single DDR3 DM lane. It runs in the `clk_div` domain and turns per-burst BL8 mask requests into the 4-bit parallel data and tristate words consumed by the DM serializer/ODELAY/IOBUF stage downstream. It also drives that stage's DCI termination control. It serializes ODELAY reprogramming so that a new delay is applied only while the lane is idle.

## Interface
Parameters:
- `WR_PRE_CYCLES`, 1 — `clk_div` cycles of output enable (tin=0, din=0) before the first data cycle of a write run; range 0..3.
- `WR_POST_CYCLES`, 1 — `clk_div` cycles of output enable after the last data cycle of a write run; range 0..3.
- `ODELAY_VALUE`, 0 — reset value of `dly_data`.

Ports:
- `clk_div` — input, 1 — sole clock. One clock; all logic is on its rising edge.
- `rst` — input, 1 — reset, synchronous, active-high.
- `wr_valid` — input, 1 — a burst request is present.
- `wr_mask` — input, 8 — BL8 mask bits; bit 0 is the first beat; 1 = masked.
- `wr_ready` — output, 1 — request accepted when `wr_valid & wr_ready`.
- `term_en` — input, 1 — controller requests DCI termination (read window).
- `dly_req` — input, 1 — delay update request, single-cycle pulse.
- `dly_value` — input, 8 — new delay value.
- `dly_busy` — output, 1 — a delay update is in progress.
- `din` — output, 4 — parallel DM data to the serializer; bit 0 is serialized first.
- `tin` — output, 4 — parallel tristate control; 1 = high-Z.
- `dci_disable` — output, 1 — 1 = DCI termination off.
- `dly_data` — output, 8 — delay value to the ODELAY stage.
- `set_odelay` — output, 1 — one-cycle pulse that loads `dly_data` into the ODELAY stage.
- `ld_odelay` — output, 1 — one-cycle pulse that applies the loaded delay.
- `term_err` — output, 1 — sticky flag: `term_en` was seen while the lane was driving.

## Operation
- Write FSM states: IDLE, PRE, D0, D1, POST.
  - PRE and POST each use a down-counter loaded from the corresponding parameter.
- `wr_ready` is combinational and equals `~rst & (D1 | POST | (IDLE & ~ld_pend))`.
- Transitions on accept:
  - From IDLE: go to PRE if `WR_PRE_CYCLES > 0`, otherwise to D0.
  - From D1 or POST: go to D0. This gives gapless back-to-back bursts with no new preamble.
- Other transitions:
  - PRE goes to D0 when its counter expires.
  - D0 always goes to D1.
  - D1 without an accept goes to POST if `WR_POST_CYCLES > 0`, otherwise to IDLE.
  - POST goes to IDLE when its counter expires, unless a burst is accepted.
- Accepted `wr_mask` is held in a register:
  - In D0, `din = mask[3:0]`.
  - In D1, `din = mask[7:4]`.
  - In every other state, `din = 0`.
- `tin = 4'b1111` in IDLE; `tin = 4'b0000` in PRE, D0, D1 and POST.
- `dci_disable` is 0 only when `term_en` is high and the FSM is in IDLE; otherwise it is 1. Writes always win over termination.
- `term_err` is set when `term_en` is high in any non-IDLE state. It is cleared only by `rst`.
- Delay path:
  - A `dly_req` while `dly_busy` is 0 latches `dly_value` into `dly_data`, sets `dly_busy` and `ld_pend`, and pulses `set_odelay` in the next cycle.
  - A `dly_req` while `dly_busy` is 1 is ignored.
  - `ld_odelay` pulses in the first cycle in which the FSM is in IDLE, `ld_pend` is 1, and `set_odelay` is not asserted. In that cycle `wr_ready` is 0, because the delay takes priority over the write.
  - `ld_pend` and `dly_busy` clear at the end of the `ld_odelay` cycle.

## Timing
- All outputs except `wr_ready` are registered and reflect the FSM state of the same cycle.
- Accept at cycle N from IDLE:
  - PRE occupies cycles N+1 .. N+WR_PRE_CYCLES.
  - D0 is at cycle N+1+WR_PRE_CYCLES and D1 follows it.
  - POST takes the next WR_POST_CYCLES cycles, then IDLE.
- With `WR_PRE_CYCLES = WR_POST_CYCLES = 0`, an accept in IDLE puts D0 at N+1.
- Sustained back-to-back throughput is one burst per 2 cycles, with `tin` held at 0 continuously.
- `dly_req` at cycle N with the FSM idle:
  - `set_odelay` at N+1.
  - `ld_odelay` at N+2.
  - `dly_busy` is high from N+1 through N+2 and low at N+3.
- `dly_req` during a write run: `set_odelay` at N+1, and `ld_odelay` in the first IDLE cycle after POST.
- Reset state:
  - FSM in IDLE.
  - `din = 0`, `tin = 4'hF`, `dci_disable = 1`.
  - `set_odelay`, `ld_odelay`, `dly_busy` and `term_err` all 0.
  - `dly_data = ODELAY_VALUE`, mask register 0.
  - `rst` mid-burst aborts the run: outputs take reset values at the next edge and the pending delay load is discarded.
- Simultaneous `wr_valid` and the `ld_odelay` cycle in IDLE: the write is not accepted and is taken in the following cycle.

## Test plan
- Single burst, defaults, accept `wr_mask = 8'hA5` at N:
  - `tin = 0` on N+1..N+4.
  - `din = 0` at N+1, `4'h5` at N+2, `4'hA` at N+3, `0` at N+4.
  - `tin = F` at N+5.
- Three back-to-back bursts `8'h01`, `8'h80`, `8'hFF` with `wr_valid` held high:
  - `din` sequence after the preamble is `1, 0, 0, 8, F, F`.
  - `tin` stays 0 with no gap; `wr_ready` is high in each D1 cycle.
- `WR_PRE_CYCLES = 0`, `WR_POST_CYCLES = 0`, accept at N: D0 at N+1, D1 at N+2, `tin = F` at N+3.
- `dly_req` with `dly_value = 8'h3C` during D0 of a burst:
  - `dly_data = 8'h3C` and `set_odelay` at the next cycle.
  - `ld_odelay` only at the first IDLE cycle after POST.
  - A second `dly_req` while `dly_busy` is 1 leaves `dly_data` unchanged.
- `term_en` held high across a burst: `dci_disable = 0` in IDLE, 1 during PRE..POST, and `term_err` is set and stays 1 until `rst`.
- `rst` asserted in D1 with a delay load pending: next cycle `tin = F`, `din = 0`, `dly_busy = 0`, and no `ld_odelay` ever follows.
